// File: rtl/tlul_host_tempsense_poller.sv
// TL-UL initiator that runs one temperature-sensor conversion: reset pulse, SEL, enable, DONE polling,
// DOUT read, disable. Define TEMPSENSE_POLL_TIMEOUT_EN to give up after MaxPolls unsuccessful DONE reads.
module tlul_host_tempsense_poller #(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter logic [7:0]  SourceId = 8'd0,
  parameter int unsigned PollGap  = 16,
  parameter int unsigned MaxPolls = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  conv_time_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [23:0] dout_o,
  output logic        tl_a_valid_o,
  output logic [2:0]  tl_a_opcode_o,
  output logic [2:0]  tl_a_param_o,
  output logic [1:0]  tl_a_size_o,
  output logic [7:0]  tl_a_source_o,
  output logic [31:0] tl_a_address_o,
  output logic [3:0]  tl_a_mask_o,
  output logic [31:0] tl_a_data_o,
  output logic [13:0] tl_a_user_o,
  output logic        tl_d_ready_o,
  input  logic        tl_d_valid_i,
  input  logic [2:0]  tl_d_opcode_i,
  input  logic [2:0]  tl_d_param_i,
  input  logic [1:0]  tl_d_size_i,
  input  logic [7:0]  tl_d_source_i,
  input  logic        tl_d_sink_i,
  input  logic [31:0] tl_d_data_i,
  input  logic [13:0] tl_d_user_i,
  input  logic        tl_d_error_i,
  input  logic        tl_a_ready_i
);
  typedef enum logic [3:0] {
    S_IDLE, S_RST0, S_RST1, S_SEL, S_EN, S_POLL, S_GAP, S_DOUT, S_DIS, S_FIN
  } state_t;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] GET      = 3'd4;

  state_t      state_reg, state_next;
  logic        rsp_reg, rsp_next;
  logic [3:0]  conv_reg;
  logic        err_reg;
  logic [23:0] dout_reg;
  logic [31:0] gap_cnt_reg;
  logic [15:0] poll_cnt_reg;

  logic        in_access, is_write;
  logic [7:0]  offset;
  logic [31:0] wdata;
  logic        rsp_fire, rsp_err, gap_last, poll_timeout, timeout_hit;

  assign rsp_err  = tl_d_error_i | (tl_d_source_i != SourceId);
  assign rsp_fire = in_access & rsp_reg & tl_d_valid_i;
  assign gap_last = (gap_cnt_reg + 32'd1) >= PollGap;
`ifdef TEMPSENSE_POLL_TIMEOUT_EN
  assign poll_timeout = ({16'd0, poll_cnt_reg} + 32'd1) >= MaxPolls;
`else
  assign poll_timeout = 1'b0;
`endif
  assign timeout_hit = rsp_fire & (state_reg == S_POLL) & ~rsp_err & ~tl_d_data_i[0] & poll_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= S_IDLE;
      rsp_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rsp_reg   <= rsp_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_reg     <= 4'd0;
      err_reg      <= 1'b0;
      dout_reg     <= 24'd0;
      gap_cnt_reg  <= 32'd0;
      poll_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == S_IDLE && start_i) begin
        conv_reg     <= conv_time_i;
        poll_cnt_reg <= 16'd0;
      end else if (rsp_fire && state_reg == S_POLL && !rsp_err && poll_cnt_reg != 16'hFFFF) begin
        poll_cnt_reg <= poll_cnt_reg + 16'd1;
      end
      gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + 32'd1 : 32'd0;
      // The error flag is sticky for one conversion and dropped as FIN hands back to IDLE.
      if (state_reg == S_FIN) err_reg <= 1'b0;
      else if ((rsp_fire && rsp_err) || timeout_hit) err_reg <= 1'b1;
      if (rsp_fire && state_reg == S_DOUT && !rsp_err) dout_reg <= tl_d_data_i[23:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    rsp_next   = rsp_reg;
    case (state_reg)
      S_IDLE: if (start_i) begin
        state_next = S_RST0;
        rsp_next   = 1'b0;
      end
      S_GAP: if (gap_last) begin
        state_next = S_POLL;
        rsp_next   = 1'b0;
      end
      S_FIN: state_next = S_IDLE;
      default: begin
        if (!rsp_reg) begin
          if (tl_a_ready_i) rsp_next = 1'b1;
        end else if (tl_d_valid_i) begin
          rsp_next = 1'b0;
          // Once enable may have been written the sensor is always switched off again.
          if (rsp_err) begin
            state_next = (state_reg == S_EN || state_reg == S_POLL || state_reg == S_DOUT) ? S_DIS : S_FIN;
          end else begin
            case (state_reg)
              S_RST0: state_next = S_RST1;
              S_RST1: state_next = S_SEL;
              S_SEL:  state_next = S_EN;
              S_EN:   state_next = S_POLL;
              S_POLL: begin
                if (tl_d_data_i[0])    state_next = S_DOUT;
                else if (poll_timeout) state_next = S_DIS;
                else if (PollGap == 0) state_next = S_POLL;
                else                   state_next = S_GAP;
              end
              S_DOUT:  state_next = S_DIS;
              default: state_next = S_FIN;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    in_access = 1'b1;
    is_write  = 1'b1;
    offset    = 8'h00;
    wdata     = 32'd0;
    case (state_reg)
      S_RST0:  offset = 8'h04;
      S_RST1:  begin offset = 8'h04; wdata = 32'd1; end
      S_SEL:   begin offset = 8'h08; wdata = {28'd0, conv_reg}; end
      S_EN:    begin offset = 8'h0C; wdata = 32'd1; end
      S_POLL:  begin offset = 8'h18; is_write = 1'b0; end
      S_DOUT:  begin offset = 8'h14; is_write = 1'b0; end
      S_DIS:   offset = 8'h0C;
      default: in_access = 1'b0;
    endcase
    busy_o         = (state_reg != S_IDLE);
    done_o         = (state_reg == S_FIN);
    err_o          = (state_reg == S_FIN) & err_reg;
    dout_o         = dout_reg;
    tl_a_valid_o   = in_access & ~rsp_reg;
    tl_d_ready_o   = in_access & rsp_reg;
    tl_a_opcode_o  = is_write ? PUT_FULL : GET;
    tl_a_param_o   = 3'd0;
    tl_a_size_o    = 2'd2;
    tl_a_source_o  = SourceId;
    tl_a_address_o = BaseAddr + {24'd0, offset};
    tl_a_mask_o    = 4'hF;
    tl_a_data_o    = wdata;
    tl_a_user_o    = 14'd0;
  end

  logic unused_tl;
  assign unused_tl = ^{tl_d_opcode_i, tl_d_param_i, tl_d_size_i, tl_d_sink_i, tl_d_user_i,
                       tl_d_data_i[31:24], MaxPolls};
endmodule

// File: tb/tb_tlul_host_tempsense_poller.sv
// Randomised bench for tlul_host_tempsense_poller: a behavioural TL-UL sensor device plus a
// sequence-level model of the expected bus accesses, result and error flag.
module tb_tlul_host_tempsense_poller;
  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [7:0]  SRC  = 8'h05;
  localparam int          GAP  = 4;
  localparam int          MAXP = 8;
  localparam logic [2:0]  PUT  = 3'd0;
  localparam logic [2:0]  GETOP = 3'd4;
`ifdef TEMPSENSE_POLL_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] conv_time;
  logic busy, done, err;
  logic [23:0] dout;
  logic tl_a_valid, tl_d_ready, tl_d_valid, tl_d_sink, tl_d_error, tl_a_ready;
  logic [2:0] tl_a_opcode, tl_a_param, tl_d_opcode, tl_d_param;
  logic [1:0] tl_a_size, tl_d_size;
  logic [7:0] tl_a_source, tl_d_source;
  logic [31:0] tl_a_address, tl_a_data, tl_d_data;
  logic [3:0] tl_a_mask;
  logic [13:0] tl_a_user, tl_d_user;

  always #5 clk = ~clk;

  tlul_host_tempsense_poller #(.BaseAddr(BASE), .SourceId(SRC), .PollGap(GAP), .MaxPolls(MAXP)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .conv_time_i(conv_time),
    .busy_o(busy), .done_o(done), .err_o(err), .dout_o(dout),
    .tl_a_valid_o(tl_a_valid), .tl_a_opcode_o(tl_a_opcode), .tl_a_param_o(tl_a_param),
    .tl_a_size_o(tl_a_size), .tl_a_source_o(tl_a_source), .tl_a_address_o(tl_a_address),
    .tl_a_mask_o(tl_a_mask), .tl_a_data_o(tl_a_data), .tl_a_user_o(tl_a_user),
    .tl_d_ready_o(tl_d_ready), .tl_d_valid_i(tl_d_valid), .tl_d_opcode_i(tl_d_opcode),
    .tl_d_param_i(tl_d_param), .tl_d_size_i(tl_d_size), .tl_d_source_i(tl_d_source),
    .tl_d_sink_i(tl_d_sink), .tl_d_data_i(tl_d_data), .tl_d_user_i(tl_d_user),
    .tl_d_error_i(tl_d_error), .tl_a_ready_i(tl_a_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Device configuration (written by the main sequence, read by the device model)
  bit          cfg_zero_wait;
  int          cfg_stall_idx, cfg_stall_len, cfg_done_zeros, cfg_err_at, cfg_bad_at, cfg_done_dly;
  logic [23:0] cfg_dout;

  logic [66:0] log_q[$];
  logic [66:0] exp_q[$];
  int          dev_idx, dev_polls, model_idx;
  logic [23:0] exp_dout;
  bit          exp_err;

  // Reference model: the list of accesses one conversion should produce
  function automatic bit emit(input logic [2:0] op, input logic [7:0] off, input logic [31:0] data);
    bit e;
    e = (model_idx == cfg_err_at) || (model_idx == cfg_bad_at);
    exp_q.push_back({op, BASE + {24'd0, off}, data});
    model_idx++;
    return e;
  endfunction

  task automatic build_model(input logic [3:0] conv);
    bit e, got_done;
    int polls;
    exp_q.delete();
    model_idx = 0;
    got_done = 0;
    e = emit(PUT, 8'h04, 32'd0);
    if (!e) e = emit(PUT, 8'h04, 32'd1);
    if (!e) e = emit(PUT, 8'h08, {28'd0, conv});
    if (!e) begin
      e = emit(PUT, 8'h0C, 32'd1);
      polls = 0;
      while (!e && !got_done && polls < 3000) begin
        polls++;
        if (emit(GETOP, 8'h18, 32'd0)) e = 1;
        else if (polls > cfg_done_zeros) got_done = 1;
        else if (TIMEOUT_EN && polls >= MAXP) e = 1;
      end
      if (got_done) begin
        if (emit(GETOP, 8'h14, 32'd0)) e = 1;
        else exp_dout = cfg_dout;
      end
      if (emit(PUT, 8'h0C, 32'd0)) e = 1;
    end
    exp_err = e;
  endtask

  // Behavioural sensor device: acts at each falling edge
  initial begin : device
    bit offered, req_seen, stable_ok, rsp_pending, last_was_poll, rsp_e, rsp_b;
    int rsp_wait, stall_cnt, idle_run;
    logic [97:0] req_cap;
    logic [30:0] req_const;
    logic [66:0] req_log;
    logic [31:0] rsp_data, rnd;
    offered = 0; req_seen = 0; stable_ok = 1; rsp_pending = 0; last_was_poll = 0;
    rsp_wait = 0; stall_cnt = 0; idle_run = 0; rsp_e = 0; rsp_b = 0; rsp_data = 0;
    req_cap = '0; req_const = '0; req_log = '0;
    tl_a_ready = 0; tl_d_valid = 0; tl_d_error = 0; tl_d_source = SRC; tl_d_data = 0;
    tl_d_opcode = 0; tl_d_param = 0; tl_d_size = 2'd2; tl_d_sink = 0; tl_d_user = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tl_a_ready = 0; tl_d_valid = 0; tl_d_error = 0; tl_d_source = SRC;
        offered = 0; req_seen = 0; rsp_pending = 0; last_was_poll = 0; idle_run = 0;
        continue;
      end
      tl_d_valid = 0; tl_d_error = 0; tl_d_source = SRC;
      if (offered) begin
        check("a_stable", stable_ok, 1'b1);
        check("a_const", req_const, {3'd0, 2'd2, SRC, 4'hF, 14'd0});
        log_q.push_back(req_log);
        rsp_e = (dev_idx == cfg_err_at);
        rsp_b = (dev_idx == cfg_bad_at);
        rnd = $urandom();
        if (req_log[63:32] == BASE + 32'h18) begin
          dev_polls++;
          rsp_data = {rnd[31:1], (dev_polls > cfg_done_zeros)};
        end else if (req_log[63:32] == BASE + 32'h14) begin
          rsp_data = {rnd[31:24], cfg_dout};
        end else begin
          rsp_data = rnd;
        end
        rsp_wait = (cfg_zero_wait ? 0 : int'($urandom_range(0, 2))) +
                   ((req_log[63:32] == BASE + 32'h18) ? cfg_done_dly : 0);
        last_was_poll = (req_log[63:32] == BASE + 32'h18);
        rsp_pending = 1; dev_idx++; tl_a_ready = 0; offered = 0; req_seen = 0;
      end
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          tl_d_valid = 1; tl_d_data = rsp_data; tl_d_error = rsp_e;
          tl_d_source = rsp_b ? SRC + 8'd1 : SRC;
          tl_d_opcode = (req_log[66:64] == GETOP) ? 3'd1 : 3'd0;
          rsp_pending = 0;
        end else begin
          rsp_wait--;
        end
      end
      if (tl_a_valid) begin
        if (!req_seen) begin
          req_seen = 1; stable_ok = 1; stall_cnt = 0;
          req_cap = {tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data, tl_a_user};
          req_const = {tl_a_param, tl_a_size, tl_a_source, tl_a_mask, tl_a_user};
          req_log = {tl_a_opcode, tl_a_address, tl_a_data};
          if (tl_a_address == BASE + 32'h18 && last_was_poll) check("poll_gap", idle_run, GAP);
        end else if ({tl_a_opcode, tl_a_param, tl_a_size, tl_a_source, tl_a_address, tl_a_mask,
                      tl_a_data, tl_a_user} !== req_cap) begin
          stable_ok = 0;
        end
        idle_run = 0;
        if (dev_idx == cfg_stall_idx && stall_cnt < cfg_stall_len) begin
          stall_cnt++;
          tl_a_ready = 0;
        end else begin
          tl_a_ready = cfg_zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
        end
        offered = tl_a_ready;
      end else begin
        tl_a_ready = 0;
        if (tl_d_ready) idle_run = 0;
        else if (busy) idle_run++;
      end
    end
  end

  function automatic int count_polls();
    int n = 0;
    foreach (log_q[i]) if (log_q[i][63:32] == BASE + 32'h18) n++;
    return n;
  endfunction

  task automatic set_cfg(input bit zw, input int zeros, input int err_at, input int bad_at,
                         input logic [23:0] dv, input int stall_idx, input int stall_len);
    cfg_zero_wait = zw; cfg_done_zeros = zeros; cfg_err_at = err_at; cfg_bad_at = bad_at;
    cfg_dout = dv; cfg_stall_idx = stall_idx; cfg_stall_len = stall_len; cfg_done_dly = 0;
  endtask

  task automatic run_conv(input logic [3:0] conv, input bit expect_done, input int budget, input bit check_lat);
    int cyc;
    bit done_seen, busy_ok, err_got;
    build_model(conv);
    dev_idx = 0; dev_polls = 0; log_q.delete();
    @(negedge clk);
    start = 1; conv_time = conv;
    cyc = 0; done_seen = 0; busy_ok = 1; err_got = 0;
    while (!done_seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_seen = 1; err_got = err; start = 0;
      end else begin
        if (!busy) busy_ok = 0;
        start = ($urandom_range(0, 7) == 0);
        conv_time = 4'($urandom_range(0, 15));
      end
    end
    start = 0;
    if (expect_done) begin
      check("done_seen", done_seen, 1'b1);
      check("busy_hold", busy_ok, 1'b1);
      if (done_seen) begin
        check("err_o", err_got, exp_err);
        check("dout_o", dout, exp_dout);
        if (check_lat) check("latency", cyc, 15);
        check("n_txn", log_q.size(), exp_q.size());
        @(negedge clk);
        check("idle_after", {done, busy, err}, 3'b000);
      end
    end else begin
      check("no_done", done_seen, 1'b0);
    end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check($sformatf("txn%0d", i), log_q[i], exp_q[i]);
    $display("run conv=%0h txns=%0d polls=%0d done=%0b err=%0b dout=%06h", conv, log_q.size(),
             count_polls(), done_seen, err_got, dout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1; start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 0;
    exp_dout = 24'd0;
  endtask

  initial begin : main
    bit found;
    rst = 1; start = 0; conv_time = 0; exp_dout = 0; exp_err = 0;
    set_cfg(1, 0, -1, -1, 24'h0, -1, 0);
    repeat (3) @(negedge clk);
    check("rst_state", {tl_a_valid, tl_d_ready, busy, done, err, dout}, 29'd0);
    #2 rst = 0;
    @(negedge clk);
    check("post_rst", {tl_a_valid, tl_d_ready, busy, done, err, dout}, 29'd0);

    set_cfg(1, 0, -1, -1, 24'hA5A5A5, -1, 0);
    run_conv(4'h3, 1, 500, 1);
    set_cfg(1, 0, -1, -1, 24'h3C3C3C, 2, 5);
    run_conv(4'h9, 1, 500, 0);
    set_cfg(1, 3, -1, -1, 24'h0F1E2D, -1, 0);
    run_conv(4'h5, 1, 500, 0);
    check("polls_4", count_polls(), 4);
    set_cfg(1, 0, 3, -1, 24'h123456, -1, 0);
    run_conv(4'h1, 1, 500, 0);

    repeat (24) begin
      set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
              24'($urandom()), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      run_conv(4'($urandom_range(0, 15)), 1, 2000, 0);
    end

    set_cfg(0, 32'h3FFF_FFFF, -1, -1, 24'h777777, -1, 0);
`ifdef TEMPSENSE_POLL_TIMEOUT_EN
    run_conv(4'hA, 1, 2000, 0);
    check("timeout_polls", count_polls(), MAXP);
`else
    run_conv(4'hA, 0, 300, 0);
    check("keeps_polling", count_polls() > MAXP, 1'b1);
    do_reset();
    check("rst_after_stuck", {busy, done, err, dout}, 27'd0);
`endif

    set_cfg(1, 32'h3FFF_FFFF, -1, -1, 24'h0, -1, 0);
    cfg_done_dly = 10;
    dev_idx = 0; dev_polls = 0; log_q.delete();
    @(negedge clk);
    start = 1; conv_time = 4'h7;
    @(negedge clk);
    start = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      #1;
      if (log_q.size() >= 5 && tl_d_ready && !tl_d_valid) found = 1;
    end
    check("reach_rdone_rsp", found, 1'b1);
    #1 rst = 1;
    #1 check("rst_async", {tl_a_valid, tl_d_ready, busy}, 3'b000);
    @(negedge clk);
    @(negedge clk);
    #1 check("rst_hold", {tl_a_valid, tl_d_ready, busy, done, err, dout}, 29'd0);
    #1 rst = 0;
    exp_dout = 24'd0;
    $display("reset during DONE response phase applied");
    set_cfg(0, 1, -1, -1, 24'hABCDEF, -1, 0);
    run_conv(4'h2, 1, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
